// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned NIBBLES_DEFAULT = 4;
  localparam int unsigned SLICE_W         = 4;

endpackage

// File: rtl/nibble_serial_addsub_rca4.sv
// 4-bit ripple-carry adder slice, the only arithmetic path of the sequencer.
module nibble_serial_addsub_rca4
  import nibble_serial_addsub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic c;

  always_comb begin
    sum = '0;
    c   = cin;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// W-bit add/subtract computed one nibble per clock through a single RCA4 slice.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int unsigned NIBBLES = NIBBLES_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         sub,
  input  logic [SLICE_W*NIBBLES-1:0]   A,
  input  logic [SLICE_W*NIBBLES-1:0]   B,
  output logic                         ready,
  output logic                         done,
  output logic [SLICE_W*NIBBLES-1:0]   S,
  output logic                         Cout,
  output logic                         Ovfl
);

  localparam int unsigned W     = SLICE_W * NIBBLES;
  localparam int unsigned CNT_W = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovfl_q, ovfl_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  nibble_serial_addsub_rca4 u_slice (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovfl_d  = ovfl_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
          a_d     = A;
          b_d     = B ^ {W{sub}};
          carry_d = sub;
          cnt_d   = '0;
          a_msb_d = A[W-1];
          b_msb_d = B[W-1] ^ sub;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        res_d   = {slice_sum, {(W-SLICE_W){1'b0}}} | (res_q >> SLICE_W);
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          s_d     = res_d;
          cout_d  = slice_cout;
          ovfl_d  = (a_msb_q ~^ b_msb_q) & (res_d[W-1] ^ a_msb_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovfl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovfl_q  <= ovfl_d;
    end
  end

  assign ready = (state_q != RUN);
  assign done  = (state_q == DONE);
  assign S     = s_q;
  assign Cout  = cout_q;
  assign Ovfl  = ovfl_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Randomized and directed checks of nibble_serial_addsub against an arithmetic reference.
module tb_nibble_serial_addsub;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         ready, done, Cout, Ovfl;
  logic [W-1:0] S;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] prev_s = '0;

  nibble_serial_addsub #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .ready (ready),
    .done  (done),
    .S     (S),
    .Cout  (Cout),
    .Ovfl  (Ovfl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signed/unsigned integer arithmetic, independent of the nibble datapath.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 output logic [W-1:0] r, output logic c, output logic v);
    longint sa, sb, rs;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    rs = s ? sa - sb : sa + sb;
    r  = W'(rs);
    v  = (rs > (longint'(1) <<< (W-1)) - 1) || (rs < -(longint'(1) <<< (W-1)));
    c  = s ? (ua >= ub) : ((ua + ub) >= (longint'(1) <<< W));
  endfunction

  // Called at a negedge with ready=1; returns at the negedge of the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit inject);
    logic [W-1:0] er;
    logic ec, ev;
    int cyc;
    bit seen;
    ref_op(a, b, s, er, ec, ev);
    start = 1'b1; A = a; B = b; sub = s;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; sub = $urandom_range(0, 1);
    check("ready_low_in_run", ready, 0);
    seen = 0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (done) begin
        seen = 1;
        break;
      end
      if (cyc == 2) begin
        check("s_held_during_run", S, prev_s);
        if (inject) begin
          start = 1'b1; A = $urandom; B = $urandom; sub = $urandom_range(0, 1);
        end
      end
      if (cyc == 3) start = 1'b0;
    end
    check("done_seen", seen, 1);
    check("latency", cyc, NIB + 1);
    check("S", S, er);
    check("Cout", Cout, ec);
    check("Ovfl", Ovfl, ev);
    check("ready_in_done", ready, 1);
    prev_s = er;
    if (inject) begin
      int extra = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (done) extra++;
      end
      check("single_done_after_ignored_start", extra, 0);
      check("S_after_ignored_start", S, er);
    end
  endtask

  task automatic idle_gap();
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_idle", ready, 1);
  endtask

  initial begin
    int extra;
    repeat (3) @(negedge clk);
    check("rst_S", S, 0);
    check("rst_Cout", Cout, 0);
    check("rst_Ovfl", Ovfl, 0);
    check("rst_done", done, 0);
    check("rst_ready", ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h0FDC, 1'b0, 0); idle_gap();
    run_op(16'hFFFF, 16'h0001, 1'b0, 0); idle_gap();
    run_op(16'h7FFF, 16'h0001, 1'b0, 0); idle_gap();
    run_op(16'h0005, 16'h0007, 1'b1, 0); idle_gap();
    run_op(16'h8000, 16'h0001, 1'b1, 0); idle_gap();

    // Ignored start during RUN.
    run_op(16'h1111, 16'h2222, 1'b0, 1);

    // Back-to-back: second start held in the DONE cycle.
    run_op(16'hABCD, 16'h1234, 1'b1, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 0);
    idle_gap();

    // Reset mid-operation.
    start = 1'b1; A = 16'h4321; B = 16'h1111; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_S", S, 0);
    check("midrst_Cout", Cout, 0);
    check("midrst_Ovfl", Ovfl, 0);
    check("midrst_done", done, 0);
    check("midrst_ready", ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) extra++;
    end
    check("no_done_after_reset", extra, 0);
    prev_s = '0;
    run_op(16'h0F0F, 16'h00F1, 1'b0, 0);

    // Random operations, mixing back-to-back and idle gaps.
    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 7 == 0) rb = ra;
      if (n % 11 == 0) ra = {1'b1, {(W-1){1'b0}}};
      run_op(ra, rb, 1'($urandom_range(0, 1)), n % 13 == 5);
      if ($urandom_range(0, 2) == 0) idle_gap();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Sequencer that performs W-bit add/subtract (W = 4·NIBBLES) by time-multiplexing a single 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first. It holds the operands, steers the nibbles, registers the inter-nibble carry, assembles the result and runs a start/ready/done handshake. It sits between a requester needing occasional wide arithmetic and the existing RCA4 slice, trading latency for area.

## Interface
- NIBBLES, 4, number of 4-bit slices per operation (W = 4·NIBBLES, NIBBLES ≥ 2)
- clk  in  1  sole clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; accepted only when ready=1
- sub  in  1  0: S = A+B; 1: S = A−B; sampled with start
- A  in  W  operand A, sampled with start
- B  in  W  operand B, sampled with start
- ready  out  1  block can accept start
- done  out  1  one-cycle pulse: S/Cout/Ovfl valid
- S  out  W  result, held until the next accepted start completes
- Cout  out  1  carry out of MSB (subtract: 1 = no borrow)
- Ovfl  out  1  two's-complement overflow

## Operation
- Reset (async, rst_n=0): state IDLE, S=0, Cout=0, Ovfl=0, done=0, ready=1, internal carry and nibble counter 0. Reset mid-operation aborts it; no done is issued.
- States IDLE, RUN, DONE.
- IDLE: ready=1. start=1 → latch A into operand register a_q, latch B^{W{sub}} into b_q, carry_q=sub, cnt=0, sub_q=sub; go RUN.
- RUN: ready=0. Adder slice inputs are a_q[3:0], b_q[3:0], carry_q. Each cycle: a_q and b_q shift right 4; slice sum is shifted into result register from the top (result = {sum, result[W-1:4]}); carry_q = slice Cout; cnt++. When cnt = NIBBLES−1 the transition is RUN→DONE.
- Sign bits for overflow: on acceptance, record a_msb = A[W-1], b_msb = B[W-1]^sub.
- DONE (one cycle): done=1, ready=1. S = result, Cout = carry_q, Ovfl = (a_msb ~^ b_msb) & (S[W-1] ^ a_msb). S/Cout/Ovfl update at the RUN→DONE edge and hold until the next DONE.
- DONE with start=1 → accepted exactly as in IDLE (back-to-back); otherwise → IDLE.
- start while ready=0 is ignored; no queueing, no error flag. sub/A/B are don't-care except when start is accepted.
- Arithmetic is modulo 2^W; no saturation.

## Timing
- Accepting edge = t0. RUN occupies cycles t0+1 … t0+NIBBLES. done=1 in cycle t0+NIBBLES+1 (NIBBLES=4: 5 cycles after start).
- Throughput: one operation per NIBBLES+1 cycles with back-to-back start in DONE.
- ready falls the cycle after acceptance and rises in the DONE cycle.
- Outputs are registered; no combinational path from inputs to any output.
- Single adder slice is the only combinational arithmetic path (4-bit ripple + mux).

## Structure
- Shared package: state enum typedef (IDLE, RUN, DONE), default NIBBLES constant, slice width constant (4).
- One sub-module: a single RCA4 instance as the adder slice; the rest is registers, counter (ceil(log2 NIBBLES) bits) and FSM in this module.

## Test plan
- NIBBLES=4, sub=0, A=0x1234, B=0x0FDC → done at t0+5, S=0x2210, Cout=0, Ovfl=0.
- sub=0, A=0xFFFF, B=0x0001 → S=0x0000, Cout=1, Ovfl=0; A=0x7FFF, B=0x0001 → S=0x8000, Cout=0, Ovfl=1.
- sub=1, A=0x0005, B=0x0007 → S=0xFFFE, Cout=0, Ovfl=0; A=0x8000, B=0x0001 → S=0x7FFF, Cout=1, Ovfl=1.
- start pulsed at t0+2 during RUN with different operands → ignored; first result unchanged, exactly one done.
- Back-to-back: start held in DONE cycle with A=0x0001, B=0x0001 → second done 5 cycles later, S=0x0002; earlier S held in between.
- rst_n low at t0+3 → immediately S=0, Cout=0, Ovfl=0, done=0, ready=1; no done after release; new start works normally.
